// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller command interface: each grant is one activate
// plus one 64-bit burst. Define SDRAM_ARB_ROUND_ROBIN_EN for round robin instead of fixed priority.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned P0_LOCK_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [63:0]       p0_wdata,
    input  logic [7:0]        p0_wmask,
    output logic              p0_ack,
    output logic [63:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [63:0]       p1_wdata,
    input  logic [7:0]        p1_wmask,
    output logic              p1_ack,
    output logic [63:0]       p1_rdata,
    input  logic              p0_lock,
    output logic [1:0]        sdram_access_cmd,
    output logic [ADDR_W+1:0] sdram_access_addr,
    output logic [63:0]       sdram_write_buffer,
    output logic [7:0]        sdram_write_mask,
    output logic              sdram_inhibit_refresh,
    input  logic              sdram_cmd_busy,
    input  logic              sdram_read_busy,
    input  logic [63:0]       sdram_read_buffer,
    output logic              grant
);
    typedef enum logic [1:0] {StIdle, StAct, StRw, StFin} state_e;

    localparam logic [1:0] CmdNop = 2'b00;
    localparam logic [1:0] CmdRd  = 2'b01;
    localparam logic [1:0] CmdWr  = 2'b10;
    localparam logic [1:0] CmdAct = 2'b11;

    state_e              state_q;
    logic [1:0]          cmd_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [63:0]         wbuf_q;
    logic [7:0]          wmask_q;
    logic                inhibit_q;
    logic                grant_q;
    logic                p0_ack_q, p1_ack_q;
    logic [63:0]         p0_rdata_q, p1_rdata_q;
    logic                we_h_q;
    logic [ADDR_W-1:0]   addr_h_q;
    logic [63:0]         wdata_h_q;
    logic [7:0]          wmask_h_q;
    logic                busy;
    logic                pick1;

    assign busy = (cmd_q != CmdNop) | sdram_cmd_busy;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // On contention the port that was not granted last wins.
    assign pick1 = p1_req & (~p0_req | ~grant_q);
`else
    localparam int unsigned CntW = $clog2(P0_LOCK_MAX + 1);
    logic [CntW-1:0] lock_cnt_q;

    assign pick1 = p1_req & (~p0_req | (p0_lock & (lock_cnt_q == CntW'(P0_LOCK_MAX))));

    // Counts locked port-0 grants that starved a waiting port 1.
    always_ff @(posedge clk) begin
        if (reset || !p0_lock) begin
            lock_cnt_q <= '0;
        end else if (state_q == StIdle && (p0_req || p1_req)) begin
            if (pick1) begin
                lock_cnt_q <= '0;
            end else if (p1_req) begin
                lock_cnt_q <= lock_cnt_q + CntW'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cmd_q      <= CmdNop;
            addr_q     <= '0;
            wbuf_q     <= '0;
            wmask_q    <= 8'hFF;
            inhibit_q  <= 1'b0;
            grant_q    <= 1'b0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            we_h_q     <= 1'b0;
            addr_h_q   <= '0;
            wdata_h_q  <= '0;
            wmask_h_q  <= 8'hFF;
        end else begin
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;
            inhibit_q <= p0_lock;
            if (cmd_q != CmdNop) begin
                cmd_q <= CmdNop;
            end
            unique case (state_q)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        grant_q   <= pick1;
                        we_h_q    <= pick1 ? p1_we    : p0_we;
                        addr_h_q  <= pick1 ? p1_addr  : p0_addr;
                        wdata_h_q <= pick1 ? p1_wdata : p0_wdata;
                        wmask_h_q <= pick1 ? p1_wmask : p0_wmask;
                        state_q   <= StAct;
                    end
                end
                StAct: begin
                    if (!busy) begin
                        cmd_q   <= CmdAct;
                        addr_q  <= {addr_h_q, 2'b00};
                        state_q <= StRw;
                    end
                end
                StRw: begin
                    if (!busy) begin
                        cmd_q  <= we_h_q ? CmdWr : CmdRd;
                        addr_q <= {addr_h_q, 2'b00};
                        if (we_h_q) begin
                            wbuf_q  <= wdata_h_q;
                            wmask_q <= wmask_h_q;
                        end
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    if (!busy && !sdram_read_busy) begin
                        if (grant_q) begin
                            p1_ack_q <= 1'b1;
                            if (!we_h_q) p1_rdata_q <= sdram_read_buffer;
                        end else begin
                            p0_ack_q <= 1'b1;
                            if (!we_h_q) p0_rdata_q <= sdram_read_buffer;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sdram_access_cmd      = cmd_q;
    assign sdram_access_addr     = addr_q;
    assign sdram_write_buffer    = wbuf_q;
    assign sdram_write_mask      = wmask_q;
    assign sdram_inhibit_refresh = inhibit_q;
    assign grant                 = grant_q;
    assign p0_ack                = p0_ack_q;
    assign p1_ack                = p1_ack_q;
    assign p0_rdata              = p0_rdata_q;
    assign p1_rdata              = p1_rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (fixed-priority build, P0_LOCK_MAX=3).
module tb_sdram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we, p0_lock;
    logic [21:0] p0_addr, p1_addr;
    logic [63:0] p0_wdata, p1_wdata;
    logic [7:0]  p0_wmask, p1_wmask;
    logic        p0_ack, p1_ack;
    logic [63:0] p0_rdata, p1_rdata;
    logic [1:0]  sdram_access_cmd;
    logic [23:0] sdram_access_addr;
    logic [63:0] sdram_write_buffer;
    logic [7:0]  sdram_write_mask;
    logic        sdram_inhibit_refresh;
    logic        sdram_cmd_busy, sdram_read_busy;
    logic [63:0] sdram_read_buffer;
    logic        grant;

    int vectors = 0;
    int miscompares = 0;

    sdram_port_arbiter #(.ADDR_W(22), .P0_LOCK_MAX(3)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .p0_req                (p0_req),
        .p0_we                 (p0_we),
        .p0_addr               (p0_addr),
        .p0_wdata              (p0_wdata),
        .p0_wmask              (p0_wmask),
        .p0_ack                (p0_ack),
        .p0_rdata              (p0_rdata),
        .p1_req                (p1_req),
        .p1_we                 (p1_we),
        .p1_addr               (p1_addr),
        .p1_wdata              (p1_wdata),
        .p1_wmask              (p1_wmask),
        .p1_ack                (p1_ack),
        .p1_rdata              (p1_rdata),
        .p0_lock               (p0_lock),
        .sdram_access_cmd      (sdram_access_cmd),
        .sdram_access_addr     (sdram_access_addr),
        .sdram_write_buffer    (sdram_write_buffer),
        .sdram_write_mask      (sdram_write_mask),
        .sdram_inhibit_refresh (sdram_inhibit_refresh),
        .sdram_cmd_busy        (sdram_cmd_busy),
        .sdram_read_busy       (sdram_read_busy),
        .sdram_read_buffer     (sdram_read_buffer),
        .grant                 (grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (sdram_access_cmd !== 2'b00) begin
            miscompares++; $display("FAIL reset_cmd got %h expected 0", sdram_access_cmd);
        end
        vectors++;
        if (sdram_access_addr !== 24'h0) begin
            miscompares++; $display("FAIL reset_addr got %h expected 0", sdram_access_addr);
        end
        vectors++;
        if (sdram_write_buffer !== 64'h0 || sdram_write_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_wbuf got %h/%h expected 0/ff", sdram_write_buffer, sdram_write_mask);
        end
        vectors++;
        if ({p0_ack, p1_ack, grant, sdram_inhibit_refresh} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b expected 0000",
                     {p0_ack, p1_ack, grant, sdram_inhibit_refresh});
        end
        vectors++;
        if (p0_rdata !== 64'h0 || p1_rdata !== 64'h0) begin
            miscompares++; $display("FAIL reset_rdata got %h/%h expected 0/0", p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_p1_read();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 22'h000123;
        sdram_read_buffer = 64'h0123456789ABCDEF;
        tick();  // edge N
        vectors++;
        if (grant !== 1'b1) begin
            miscompares++; $display("FAIL p1rd_grant got %b expected 1", grant);
        end
        tick();  // N+1
        vectors++;
        if (sdram_access_cmd !== 2'b11 || sdram_access_addr !== 24'h00048C) begin
            miscompares++;
            $display("FAIL p1rd_act got %h/%h expected 3/00048c", sdram_access_cmd, sdram_access_addr);
        end
        tick();  // N+2
        vectors++;
        if (sdram_access_cmd !== 2'b00) begin
            miscompares++; $display("FAIL p1rd_gap got %h expected 0", sdram_access_cmd);
        end
        tick();  // N+3
        vectors++;
        if (sdram_access_cmd !== 2'b01 || sdram_access_addr !== 24'h00048C) begin
            miscompares++;
            $display("FAIL p1rd_rd got %h/%h expected 1/00048c", sdram_access_cmd, sdram_access_addr);
        end
        tick();  // N+4
        vectors++;
        if (p1_ack !== 1'b0) begin
            miscompares++; $display("FAIL p1rd_early_ack got %b expected 0", p1_ack);
        end
        tick();  // N+5
        vectors++;
        if (p1_ack !== 1'b1 || p1_rdata !== 64'h0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL p1rd_ack got %b/%h expected 1/0123456789abcdef", p1_ack, p1_rdata);
        end
        p1_req = 1'b0;
        tick();
        vectors++;
        if (p1_ack !== 1'b0 || sdram_access_cmd !== 2'b00) begin
            miscompares++;
            $display("FAIL p1rd_ack_pulse got %b/%h expected 0/0", p1_ack, sdram_access_cmd);
        end
    endtask

    task automatic test_p0_write();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 22'h3FFFFF;
        p0_wdata = 64'hFFFF_FFFF_FFFF_FFFF; p0_wmask = 8'h0F;
        tick();
        tick();
        vectors++;
        if (sdram_access_cmd !== 2'b11 || sdram_access_addr !== 24'hFFFFFC) begin
            miscompares++;
            $display("FAIL p0wr_act got %h/%h expected 3/fffffc", sdram_access_cmd, sdram_access_addr);
        end
        tick();
        tick();
        vectors++;
        if (sdram_access_cmd !== 2'b10 || sdram_access_addr !== 24'hFFFFFC) begin
            miscompares++;
            $display("FAIL p0wr_wr got %h/%h expected 2/fffffc", sdram_access_cmd, sdram_access_addr);
        end
        vectors++;
        if (sdram_write_buffer !== 64'hFFFF_FFFF_FFFF_FFFF || sdram_write_mask !== 8'h0F) begin
            miscompares++;
            $display("FAIL p0wr_buf got %h/%h expected ffffffffffffffff/0f",
                     sdram_write_buffer, sdram_write_mask);
        end
        tick();
        tick();
        vectors++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL p0wr_ack got %b/%b/%h expected 1/0/0", p0_ack, p1_ack, p0_rdata);
        end
        p0_req = 1'b0;
        tick();
        vectors++;
        if (p0_ack !== 1'b0) begin
            miscompares++; $display("FAIL p0wr_ack_pulse got %b expected 0", p0_ack);
        end
    endtask

    task automatic test_simultaneous();
        int seq[2];
        int n = 0;
        p0_we = 1'b0; p1_we = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 0; c < 40 && n < 2; c++) begin
            tick();
            if (p0_ack) begin seq[n] = 0; n++; p0_req = 1'b0; end
            if (p1_ack) begin seq[n] = 1; n++; p1_req = 1'b0; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        vectors++;
        if (n !== 2) begin
            miscompares++; $display("FAIL simul_count got %0d expected 2", n);
        end else begin
            vectors++;
            if (seq[0] !== 0 || seq[1] !== 1) begin
                miscompares++;
                $display("FAIL simul_order got %0d,%0d expected 0,1", seq[0], seq[1]);
            end
        end
        tick();
    endtask

    task automatic test_lock();
        int seq[8];
        int exp_seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int n = 0;
        p0_lock = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 0; c < 200 && n < 8; c++) begin
            tick();
            if (c == 0) begin
                vectors++;
                if (sdram_inhibit_refresh !== 1'b1) begin
                    miscompares++; $display("FAIL lock_inhibit got %b expected 1", sdram_inhibit_refresh);
                end
            end
            if (p0_ack) begin seq[n] = 0; n++; end
            if (p1_ack) begin seq[n] = 1; n++; end
        end
        p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0;
        vectors++;
        if (n !== 8) begin
            miscompares++; $display("FAIL lock_count got %0d expected 8", n);
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (seq[i] !== exp_seq[i]) begin
                    miscompares++;
                    $display("FAIL lock_seq[%0d] got %0d expected %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
        tick();
        tick();
        vectors++;
        if (sdram_inhibit_refresh !== 1'b0) begin
            miscompares++; $display("FAIL lock_inhibit_off got %b expected 0", sdram_inhibit_refresh);
        end
    endtask

    task automatic test_busy();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 22'h000ABC;
        sdram_read_buffer = 64'hDEADBEEFCAFEF00D;
        tick();
        tick();
        vectors++;
        if (sdram_access_cmd !== 2'b11) begin
            miscompares++; $display("FAIL busy_act got %h expected 3", sdram_access_cmd);
        end
        sdram_cmd_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (sdram_access_cmd !== 2'b00) begin
                miscompares++;
                $display("FAIL busy_hold[%0d] got %h expected 0", i, sdram_access_cmd);
            end
        end
        sdram_cmd_busy = 1'b0;
        tick();
        vectors++;
        if (sdram_access_cmd !== 2'b01) begin
            miscompares++; $display("FAIL busy_rd got %h expected 1", sdram_access_cmd);
        end
        sdram_read_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (p1_ack !== 1'b0 || sdram_access_cmd !== 2'b00) begin
                miscompares++;
                $display("FAIL busy_rdwait[%0d] got %b/%h expected 0/0", i, p1_ack, sdram_access_cmd);
            end
        end
        sdram_read_busy = 1'b0;
        tick();
        vectors++;
        if (p1_ack !== 1'b1 || p1_rdata !== 64'hDEADBEEFCAFEF00D) begin
            miscompares++;
            $display("FAIL busy_ack got %b/%h expected 1/deadbeefcafef00d", p1_ack, p1_rdata);
        end
        p1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int got_ack = 0;
        int lat = 0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 22'h000010;
        tick();
        tick();
        vectors++;
        if (sdram_access_cmd !== 2'b11) begin
            miscompares++; $display("FAIL rstmid_act got %h expected 3", sdram_access_cmd);
        end
        reset = 1'b1; p0_req = 1'b0;
        tick();
        reset = 1'b0;
        vectors++;
        if (sdram_access_cmd !== 2'b00 || p1_rdata !== 64'h0 || sdram_write_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL rstmid_state got %h/%h/%h expected 0/0/ff",
                     sdram_access_cmd, p1_rdata, sdram_write_mask);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (p0_ack || p1_ack || sdram_access_cmd != 2'b00) got_ack++;
        end
        vectors++;
        if (got_ack !== 0) begin
            miscompares++; $display("FAIL rstmid_noack got %0d expected 0", got_ack);
        end
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 22'h000055;
        sdram_read_buffer = 64'h1122334455667788;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (p1_ack) lat = i;
        end
        p1_req = 1'b0;
        vectors++;
        if (lat !== 6 || p1_rdata !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL rstmid_fresh got lat %0d data %h expected lat 6 data 1122334455667788",
                     lat, p1_rdata);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wmask = 8'hFF;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wmask = 8'hFF;
        p0_lock = 1'b0;
        sdram_cmd_busy = 1'b0; sdram_read_busy = 1'b0; sdram_read_buffer = '0;
        test_reset();
        test_p1_read();
        test_p0_write();
        test_simultaneous();
        test_lock();
        test_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
